// File: rtl/product_bcd_converter_pkg.sv
// Shared types and constants for the product-to-BCD converter.
// Holds the FSM encoding and the shift-add-3 digit adjust rule.
package product_bcd_converter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } bcd_state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // A digit of 5..9 becomes 8..12, so the next left shift carries into the next digit.
  function automatic logic [3:0] bcd_adjust(input logic [3:0] digit);
    bcd_adjust = (digit >= BCD_ADJ_THRESH) ? (digit + BCD_ADJ_ADD) : digit;
  endfunction

endpackage

// File: rtl/product_bcd_converter_bcd_digit_adj.sv
// Single-digit double-dabble adjust: add 3 when the digit is 5 or more.
// Purely combinational; replicated once per BCD digit by the top.
module bcd_digit_adj
  import product_bcd_converter_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = bcd_adjust(digit);

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential double-dabble converter: signed/unsigned product to sign + packed BCD.
// One product bit is shifted per clock; Done pulses when Bcd/Sign are refreshed.
module product_bcd_converter
  import product_bcd_converter_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      Product,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Sign,
  output logic [4*DIGITS-1:0]   Bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  bcd_state_t        state_r;
  bcd_state_t        state_next_s;
  logic [CW-1:0]     cnt_r;
  logic [WIDTH-1:0]  mag_r;
  logic [BW-1:0]     work_r;
  logic              sgn_r;
  logic [BW-1:0]     adj_s;
  logic              load_s;
  logic              start_sgn_s;
  logic [WIDTH-1:0]  start_mag_s;

  bcd_digit_adj u_adj [DIGITS-1:0] (
    .digit    (work_r),
    .adjusted (adj_s)
  );

  // Two's-complement magnitude is taken as unsigned, so the most negative value still fits.
  assign start_sgn_s = (SIGNED != 0) && Product[WIDTH-1];
  assign start_mag_s = start_sgn_s ? (~Product + WIDTH'(1)) : Product;

  // Next-state logic; DONE accepts Start so back-to-back conversions have no bubble.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (Start) begin
          state_next_s = CONV;
          load_s       = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      CONV: begin
        if (cnt_r == CNT_LAST) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CONV;
        end
      end
      DONE: begin
        if (Start) begin
          state_next_s = CONV;
          load_s       = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state register with registered status flags.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      Busy    <= (state_next_s == CONV);
      Done    <= (state_next_s == DONE);
    end
  end

  // Shift register, counter and result registers; results move only on the final shift.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_r  <= '0;
      mag_r  <= '0;
      work_r <= '0;
      sgn_r  <= 1'b0;
      Sign   <= 1'b0;
      Bcd    <= '0;
    end else if (load_s) begin
      cnt_r  <= CNT_INIT;
      mag_r  <= start_mag_s;
      work_r <= '0;
      sgn_r  <= start_sgn_s;
    end else if (state_r == CONV) begin
      {work_r, mag_r} <= {adj_s[BW-2:0], mag_r, 1'b0};
      cnt_r           <= cnt_r - CW'(1);
      if (cnt_r == CNT_LAST) begin
        Bcd  <= {adj_s[BW-2:0], mag_r[WIDTH-1]};
        Sign <= sgn_r;
      end
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed self-checking bench for product_bcd_converter (signed and unsigned builds).
module tb_product_bcd_converter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] product;
  logic        busy, done, sign;
  logic [19:0] bcd;
  logic        busy_u, done_u, sign_u;
  logic [19:0] bcd_u;

  int tests_run = 0;
  int tests_failed = 0;

  product_bcd_converter #(.WIDTH(16), .DIGITS(5), .SIGNED(1)) u_dut (
    .Clk(clk), .Reset(reset), .Start(start), .Product(product),
    .Busy(busy), .Done(done), .Sign(sign), .Bcd(bcd)
  );

  product_bcd_converter #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u_dut_unsigned (
    .Clk(clk), .Reset(reset), .Start(start), .Product(product),
    .Busy(busy_u), .Done(done_u), .Sign(sign_u), .Bcd(bcd_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive Start for exactly one rising edge (E0); returns #1 after E0.
  task automatic start_conv(input logic [15:0] p);
    @(negedge clk);
    start   = 1'b1;
    product = p;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for Done (bounded); reports cycles after E0 and whether Bcd stayed at hold_bcd until then.
  task automatic wait_done(input logic [19:0] hold_bcd, output int cycles, output bit held);
    cycles = 0;
    held   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (done) break;
      if (bcd !== hold_bcd) held = 1'b0;
    end
    if (!done) cycles = -1;
  endtask

  int  n;
  bit  held;
  int  extra_dones;

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    product = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bcd",  {12'd0, bcd},  32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Zero: latency and value
    start_conv(16'h0000);
    check("zero_busy", {31'd0, busy}, 32'd1);
    wait_done(20'h00000, n, held);
    check("zero_latency", n, 32'd16);
    check("zero_sign", {31'd0, sign}, 32'd0);
    check("zero_bcd",  {12'd0, bcd},  32'h00000);
    check("zero_busy_at_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);

    start_conv(16'h4000);
    wait_done(20'h00000, n, held);
    check("p4000_sign", {31'd0, sign}, 32'd0);
    check("p4000_bcd",  {12'd0, bcd},  32'h16384);

    start_conv(16'hC0FF);
    wait_done(20'h16384, n, held);
    check("pc0ff_sign", {31'd0, sign}, 32'd1);
    check("pc0ff_bcd",  {12'd0, bcd},  32'h16129);
    check("pc0ff_hold", {31'd0, held}, 32'd1);

    start_conv(16'h8000);
    wait_done(20'h16129, n, held);
    check("p8000_sign", {31'd0, sign}, 32'd1);
    check("p8000_bcd",  {12'd0, bcd},  32'h32768);

    start_conv(16'hFFFF);
    wait_done(20'h32768, n, held);
    check("pffff_sign", {31'd0, sign}, 32'd1);
    check("pffff_bcd",  {12'd0, bcd},  32'h00001);
    check("pffff_u_done", {31'd0, done_u}, 32'd1);
    check("pffff_u_sign", {31'd0, sign_u}, 32'd0);
    check("pffff_u_bcd",  {12'd0, bcd_u},  32'h65535);

    // Start pulsed during conversion is ignored
    start_conv(16'h4000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start   = 1'b1;
    product = 16'h1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ignore_busy", {31'd0, busy}, 32'd1);
    wait_done(20'h00001, n, held);
    check("ignore_latency", n, 32'd10);
    check("ignore_hold", {31'd0, held}, 32'd1);
    check("ignore_bcd", {12'd0, bcd}, 32'h16384);
    extra_dones = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (done) extra_dones++;
    end
    check("ignore_single_done", extra_dones, 32'd0);
    check("ignore_bcd_after", {12'd0, bcd}, 32'h16384);

    // Back-to-back: Start held through the DONE cycle
    start_conv(16'h0001);
    wait_done(20'h16384, n, held);
    check("b2b_first_bcd", {12'd0, bcd}, 32'h00001);
    start   = 1'b1;
    product = 16'h3039;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_no_bubble", {31'd0, busy}, 32'd1);
    wait_done(20'h00001, n, held);
    check("b2b_latency", n, 32'd16);
    check("b2b_hold", {31'd0, held}, 32'd1);
    check("b2b_bcd", {12'd0, bcd}, 32'h12345);

    // Asynchronous reset mid-conversion
    start_conv(16'h1234);
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_sign", {31'd0, sign}, 32'd0);
    check("arst_bcd",  {12'd0, bcd},  32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("arst_stays_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
